// File: rtl/writeback_tracker_pkg.sv
// Shared pipeline definitions for the writeback tracker:
// register address width, x0 constant, slot bundle and bubble value.
package writeback_tracker_pkg;

    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] X0 = '0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } slot_t;

    localparam slot_t BUBBLE_SLOT = '0;

    // A slot only produces a value worth forwarding when it writes a
    // real register; writes to x0 are discarded by the register file.
    function automatic logic slot_effective(slot_t s);
        return s.valid && s.regwrite && (s.rd != X0);
    endfunction

endpackage

// File: rtl/writeback_tracker_if.sv
// Decode-side inputs, control inputs and forwarding producer outputs
// of the writeback tracker; slave is the tracker, master the pipeline.
interface writeback_tracker_if #(
    parameter int REG_AW = 5
) ();

    logic              id_valid_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_use_rs1_i;
    logic              id_use_rs2_i;
    logic              flush_i;
    logic              dmem_busy_i;
    logic              stall_o;
    logic              regwrite_p_o;
    logic [REG_AW-1:0] rd_p_o;
    logic              regwrite_pp_o;
    logic [REG_AW-1:0] rd_pp_o;

    modport slave (
        input  id_valid_i, id_rd_i, id_regwrite_i, id_memread_i,
        input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
        input  flush_i, dmem_busy_i,
        output stall_o, regwrite_p_o, rd_p_o, regwrite_pp_o, rd_pp_o
    );

    modport master (
        output id_valid_i, id_rd_i, id_regwrite_i, id_memread_i,
        output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
        output flush_i, dmem_busy_i,
        input  stall_o, regwrite_p_o, rd_p_o, regwrite_pp_o, rd_pp_o
    );

endinterface

// File: rtl/writeback_tracker_stage_slot.sv
// One tracked pipeline slot: hold, load-bubble or load-next per edge,
// with an `effective` flag for forwarding and hazard logic.
module writeback_tracker_stage_slot
    import writeback_tracker_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  hold_i,
    input  logic  bubble_i,
    input  slot_t next_i,
    output slot_t slot_o,
    output logic  eff_o
);

    slot_t slot_q;
    slot_t slot_d;

    // Hold beats bubble beats normal advance.
    always_comb begin
        slot_d = next_i;
        if (hold_i) begin
            slot_d = slot_q;
        end else if (bubble_i) begin
            slot_d = BUBBLE_SLOT;
        end
    end

    // Slot register; reset empties the slot immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q <= BUBBLE_SLOT;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;
    assign eff_o  = slot_effective(slot_q);

endmodule

// File: rtl/writeback_tracker.sv
// Tracks rd/regwrite/memread through EX, MEM, WB; drives forwarding
// producers and load-use stalls. Optional counters: WB_TRACK_PERF_EN.
module writeback_tracker #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
`ifdef WB_TRACK_PERF_EN
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o,
`endif
    writeback_tracker_if.slave bus
);

    import writeback_tracker_pkg::*;

    slot_t idex_s, exmem_s, memwb_s;
    slot_t id_slot;
    logic  idex_eff, exmem_eff, memwb_eff;
    logic  hazard;
    logic  stall;
    logic  unused_memread;

    assign id_slot = '{
        valid:    bus.id_valid_i,
        rd:       bus.id_rd_i,
        regwrite: bus.id_regwrite_i,
        memread:  bus.id_memread_i
    };

    // Load in EX whose result the decode instruction needs now.
    always_comb begin
        hazard = idex_eff && idex_s.memread && bus.id_valid_i &&
                 ((bus.id_use_rs1_i && (bus.id_rs1_i == idex_s.rd)) ||
                  (bus.id_use_rs2_i && (bus.id_rs2_i == idex_s.rd)));
    end

    // A flushed consumer is discarded, so it never needs to wait.
    assign stall = hazard && !bus.flush_i;

    writeback_tracker_stage_slot u_idex (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (bus.dmem_busy_i),
        .bubble_i (bus.flush_i || stall),
        .next_i   (id_slot),
        .slot_o   (idex_s),
        .eff_o    (idex_eff)
    );

    writeback_tracker_stage_slot u_exmem (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (bus.dmem_busy_i),
        .bubble_i (1'b0),
        .next_i   (idex_s),
        .slot_o   (exmem_s),
        .eff_o    (exmem_eff)
    );

    writeback_tracker_stage_slot u_memwb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (bus.dmem_busy_i),
        .bubble_i (1'b0),
        .next_i   (exmem_s),
        .slot_o   (memwb_s),
        .eff_o    (memwb_eff)
    );

    assign unused_memread = memwb_s.memread;

    assign bus.stall_o       = stall;
    assign bus.regwrite_p_o  = exmem_eff;
    assign bus.rd_p_o        = exmem_eff ? exmem_s.rd : X0;
    assign bus.regwrite_pp_o = memwb_eff;
    assign bus.rd_pp_o       = memwb_eff ? memwb_s.rd : X0;

`ifdef WB_TRACK_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counts, frozen together with the pipeline.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!bus.dmem_busy_i) begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (bus.flush_i && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_tracker.sv
// Directed bench for writeback_tracker: reset, flow, load-use,
// x0 filter, flush-over-stall and freeze, with fixed expectations.
module tb_writeback_tracker;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    writeback_tracker_if bus ();

`ifdef WB_TRACK_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    writeback_tracker dut (
        .clk_i       (clk),
        .rst_i       (rst),
`ifdef WB_TRACK_PERF_EN
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt),
`endif
        .bus         (bus)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd,
                         input logic rw, input logic mr,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2);
        bus.id_valid_i    = v;
        bus.id_rd_i       = rd;
        bus.id_regwrite_i = rw;
        bus.id_memread_i  = mr;
        bus.id_rs1_i      = rs1;
        bus.id_rs2_i      = rs2;
        bus.id_use_rs1_i  = u1;
        bus.id_use_rs2_i  = u2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_p(input string tag, input logic rw,
                         input logic [4:0] rd);
        check({tag, ".rw_p"}, 32'(bus.regwrite_p_o), 32'(rw));
        check({tag, ".rd_p"}, 32'(bus.rd_p_o), 32'(rd));
    endtask

    task automatic chk_pp(input string tag, input logic rw,
                          input logic [4:0] rd);
        check({tag, ".rw_pp"}, 32'(bus.regwrite_pp_o), 32'(rw));
        check({tag, ".rd_pp"}, 32'(bus.rd_pp_o), 32'(rd));
    endtask

    initial begin
        idle();
        bus.flush_i     = 1'b0;
        bus.dmem_busy_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk_p("reset", 1'b0, 5'd0);
        chk_pp("reset", 1'b0, 5'd0);
        check("reset.stall", 32'(bus.stall_o), 32'd0);
`ifdef WB_TRACK_PERF_EN
        check("reset.scnt", 32'(stall_cnt), 32'd0);
        check("reset.fcnt", 32'(flush_cnt), 32'd0);
`endif

        // Reset with three writers in flight
        drive(1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        idle();
        chk_p("fill", 1'b1, 5'd2);
        chk_pp("fill", 1'b1, 5'd1);
        rst = 1'b1;
        #1;
        chk_p("midrst", 1'b0, 5'd0);
        chk_pp("midrst", 1'b0, 5'd0);
        rst = 1'b0;
        #1;
        step();
        step();
        chk_p("postrst", 1'b0, 5'd0);
        chk_pp("postrst", 1'b0, 5'd0);

        // Plain flow, ALU rd=5
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        idle();
        chk_p("flow0", 1'b0, 5'd0);
        step();
        chk_p("flow1", 1'b1, 5'd5);
        chk_pp("flow1", 1'b0, 5'd0);
        step();
        chk_p("flow2", 1'b0, 5'd0);
        chk_pp("flow2", 1'b1, 5'd5);
        step();
        step();

        // Load-use on rs2
        drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd1, 5'd7, 1'b0, 1'b1);
        #1;
        check("lu.stall", 32'(bus.stall_o), 32'd1);
        step();
        check("lu.stall1", 32'(bus.stall_o), 32'd0);
        chk_p("lu.load", 1'b1, 5'd7);
        step();
        idle();
        chk_p("lu.bub", 1'b0, 5'd0);
        chk_pp("lu.bub", 1'b1, 5'd7);
        step();
        chk_p("lu.cons", 1'b1, 5'd8);
`ifdef WB_TRACK_PERF_EN
        check("lu.scnt", 32'(stall_cnt), 32'd1);
`endif
        step();
        step();
        step();

        // x0: load to rd 0 and ALU to rd 0
        drive(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
        #1;
        check("x0.stall", 32'(bus.stall_o), 32'd0);
        drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        idle();
        step();
        chk_p("x0.alu", 1'b0, 5'd0);
        step();
        step();
        step();

        // Flush beats stall
        drive(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 5'd0, 1'b1, 1'b0);
        bus.flush_i = 1'b1;
        #1;
        check("fl.stall", 32'(bus.stall_o), 32'd0);
        step();
        bus.flush_i = 1'b0;
        idle();
        chk_p("fl.load", 1'b1, 5'd3);
`ifdef WB_TRACK_PERF_EN
        check("fl.fcnt", 32'(flush_cnt), 32'd1);
        check("fl.scnt", 32'(stall_cnt), 32'd1);
`endif
        step();
        chk_p("fl.bub", 1'b0, 5'd0);
        chk_pp("fl.ld", 1'b1, 5'd3);
        step();
        step();
        step();

        // Freeze during a hazard
        drive(1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd0, 5'd4, 1'b0, 1'b1);
        bus.dmem_busy_i = 1'b1;
        #1;
        check("fz.stall", 32'(bus.stall_o), 32'd1);
        chk_p("fz", 1'b1, 5'd11);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("fz%0d.stall", i), 32'(bus.stall_o), 32'd1);
            chk_p($sformatf("fz%0d", i), 1'b1, 5'd11);
            chk_pp($sformatf("fz%0d", i), 1'b0, 5'd0);
        end
        bus.dmem_busy_i = 1'b0;
        #1;
        check("fz.rel", 32'(bus.stall_o), 32'd1);
        step();
        check("fz.after", 32'(bus.stall_o), 32'd0);
        chk_p("fz.ld", 1'b1, 5'd4);
        chk_pp("fz.alu", 1'b1, 5'd11);
`ifdef WB_TRACK_PERF_EN
        check("fz.scnt", 32'(stall_cnt), 32'd2);
        check("fz.fcnt", 32'(flush_cnt), 32'd1);
`endif
        step();
        idle();
        chk_p("fz.bub", 1'b0, 5'd0);
        chk_pp("fz.ld", 1'b1, 5'd4);
        step();
        chk_p("fz.cons", 1'b1, 5'd10);
        check("fz.idle", 32'(bus.stall_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
